// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared opcodes, function codes, default register map and address lookup
package mips_pipe_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam int MAX_REGS = 32;
  localparam logic [29:0] DEFAULT_REG_MAP = {5'b10000, 5'b11111, 5'b10111, 5'b01000, 5'b10010, 5'b10001};
  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } lookup_t;
  // First matching map entry wins; the map is zero-padded to MAX_REGS entries, n bounds the search.
  function automatic lookup_t reg_lookup(input logic [4:0] addr, input logic [5*MAX_REGS-1:0] map, input int n);
    lookup_t r;
    r = '0;
    for (int i = 0; i < MAX_REGS; i++)
      if (i < n && !r.hit && map[5*i+:5] == addr) r = '{1'b1, 5'(i)};
    return r;
  endfunction
  function automatic logic legal_funct(input logic [5:0] f);
    return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLL, FN_SRL};
  endfunction
endpackage

// File: rtl/mips_pipe_param_if.sv
// mips_pipe_param_if: instruction/readout bus of the pipeline
//   master drives in_valid, instruction, output_reg; slave returns out_valid, instruction_fail, out_data
interface mips_pipe_param_if #(parameter int DATA_W = 32, parameter int NUM_OUT = 4);
  logic                      in_valid;
  logic [31:0]               instruction;
  logic [NUM_OUT*5-1:0]      output_reg;
  logic                      out_valid;
  logic                      instruction_fail;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  modport master(output in_valid, instruction, output_reg, input out_valid, instruction_fail, out_data);
  modport slave(input in_valid, instruction, output_reg, output out_valid, instruction_fail, out_data);
endinterface

// File: rtl/mips_pipe_alu.sv
// mips_pipe_alu: combinational ALU for R-type functions and ADDI
//   in: funct, shamt, a (rs), b (rt), imm, is_rtype; out: result
module mips_pipe_alu
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter bit SIGN_EXT = 0
) (
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [15:0]       imm,
  input  logic              is_rtype,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] r_res;
  assign ext = SIGN_EXT ? DATA_W'($signed(imm)) : DATA_W'(imm);
  // Shifts by shamt >= DATA_W naturally yield zero for logical shifts.
  always_comb begin
    r_res = '0;
    case (funct)
      FN_ADD:  r_res = a + b;
      FN_SUB:  r_res = a - b;
      FN_AND:  r_res = a & b;
      FN_OR:   r_res = a | b;
      FN_NOR:  r_res = ~(a | b);
      FN_SLT:  r_res = DATA_W'($signed(a) < $signed(b));
      FN_SLL:  r_res = a << shamt;
      FN_SRL:  r_res = a >> shamt;
      default: r_res = '0;
    endcase
  end
  assign result = is_rtype ? r_res : a + ext;
endmodule

// File: rtl/mips_pipe_param.sv
// mips_pipe_param: 4-stage MIPS subset pipeline with EX forwarding and mapped register readout
//   clk, rst_n (async, active-high); bus (slave): in_valid/instruction/output_reg in,
//   out_valid/instruction_fail/out_data out, 4 cycles after input
module mips_pipe_param
  import mips_pipe_pkg::*;
#(
  parameter int                    DATA_W   = 32,
  parameter int                    NUM_REGS = 6,
  parameter logic [NUM_REGS*5-1:0] REG_MAP  = DEFAULT_REG_MAP,
  parameter int                    NUM_OUT  = 4,
  parameter bit                    SIGN_EXT = 0
) (
  input logic clk,
  input logic rst_n,
  mips_pipe_param_if.slave bus
);
  localparam logic [5*MAX_REGS-1:0] MAP = 160'(REG_MAP);
  logic [DATA_W-1:0] rf [NUM_REGS];
  logic                 v1, v2, v3, ok2, ok3, isr2;
  logic [31:0]          ins1;
  logic [NUM_OUT*5-1:0] or1, or2, or3;
  logic [DATA_W-1:0]    a1, b1, a2, b2, res2;
  logic [5:0]           fn2;
  logic [4:0]           sh2, wd2;
  logic [15:0]          imm2;
  logic                 ok1, isr1, we2;
  logic [NUM_OUT*DATA_W-1:0] rd_data;
  lookup_t ls, lt, ld;
  assign ls   = reg_lookup(ins1[25:21], MAP, NUM_REGS);
  assign lt   = reg_lookup(ins1[20:16], MAP, NUM_REGS);
  assign ld   = reg_lookup(ins1[15:11], MAP, NUM_REGS);
  assign isr1 = ins1[31:26] == OP_R;
  assign ok1  = (isr1 || ins1[31:26] == OP_ADDI) && ls.hit && lt.hit &&
                (!isr1 || (ld.hit && legal_funct(ins1[5:0])));
  assign we2  = v2 && ok2;
  // Operand read; the instruction one stage ahead writes at this same edge, so its ALU result is bypassed.
  always_comb begin
    a1 = '0;
    b1 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ls.idx == 5'(i)) a1 = rf[i];
      if (lt.idx == 5'(i)) b1 = rf[i];
    end
    if (we2 && wd2 == ls.idx) a1 = res2;
    if (we2 && wd2 == lt.idx) b1 = res2;
  end
  mips_pipe_alu #(.DATA_W(DATA_W), .SIGN_EXT(SIGN_EXT)) u_alu (
    .funct(fn2), .shamt(sh2), .a(a2), .b(b2), .imm(imm2), .is_rtype(isr2), .result(res2)
  );
  // Readout samples the file before the next instruction's write lands at the same edge.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_OUT; k++)
      for (int i = 0; i < NUM_REGS; i++)
        if (reg_lookup(or3[5*k+:5], MAP, NUM_REGS) == {1'b1, 5'(i)}) rd_data[k*DATA_W+:DATA_W] = rf[i];
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      {v1, v2, v3, ok2, ok3, isr2} <= '0;
      {ins1, or1, or2, or3, a2, b2, fn2, sh2, wd2, imm2} <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      bus.out_valid        <= 1'b0;
      bus.instruction_fail <= 1'b0;
      bus.out_data         <= '0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        ins1 <= bus.instruction;
        or1  <= bus.output_reg;
      end
      v2   <= v1;
      ok2  <= ok1;
      a2   <= a1;
      b2   <= b1;
      fn2  <= ins1[5:0];
      sh2  <= ins1[10:6];
      imm2 <= ins1[15:0];
      isr2 <= isr1;
      wd2  <= isr1 ? ld.idx : lt.idx;
      or2  <= or1;
      for (int i = 0; i < NUM_REGS; i++)
        if (we2 && wd2 == 5'(i)) rf[i] <= res2;
      v3  <= v2;
      ok3 <= ok2;
      or3 <= or2;
      bus.out_valid        <= v3;
      bus.instruction_fail <= v3 && !ok3;
      bus.out_data         <= (v3 && ok3) ? rd_data : '0;
    end
  end
endmodule

// File: tb/tb_mips_pipe_param.sv
// tb_mips_pipe_param: three configurations driven in lockstep and checked against a sequential ISA model
module tb_mips_pipe_param;
  localparam logic [4:0] RA = 5'b10001, RB = 5'b10010, RC = 5'b01000;
  localparam logic [4:0] RD = 5'b10111, RE = 5'b11111, RF = 5'b10000;
  localparam logic [19:0] ORD = {RD, RC, RB, RA};
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [31:0] instruction = '0;
  logic [19:0] output_reg = '0;
  always #5 clk = ~clk;
  mips_pipe_param_if #(.DATA_W(32), .NUM_OUT(4)) b0 ();
  mips_pipe_param_if #(.DATA_W(32), .NUM_OUT(4)) b1 ();
  mips_pipe_param_if #(.DATA_W(16), .NUM_OUT(4)) b2 ();
  assign b0.in_valid = in_valid;
  assign b1.in_valid = in_valid;
  assign b2.in_valid = in_valid;
  assign b0.instruction = instruction;
  assign b1.instruction = instruction;
  assign b2.instruction = instruction;
  assign b0.output_reg = output_reg;
  assign b1.output_reg = output_reg;
  assign b2.output_reg = output_reg;
  mips_pipe_param #(.DATA_W(32), .SIGN_EXT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mips_pipe_param #(.DATA_W(32), .SIGN_EXT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mips_pipe_param #(.DATA_W(16), .SIGN_EXT(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  logic [127:0] od [3];
  logic ov [3], of [3];
  assign od[0] = b0.out_data;
  assign od[1] = b1.out_data;
  assign od[2] = {64'd0, b2.out_data};
  assign ov[0] = b0.out_valid;
  assign ov[1] = b1.out_valid;
  assign ov[2] = b2.out_valid;
  assign of[0] = b0.instruction_fail;
  assign of[1] = b1.instruction_fail;
  assign of[2] = b2.instruction_fail;
  typedef struct {int due; bit fail; logic [127:0] data;} exp_t;
  typedef struct {int d; int due; int id; bit fail; logic [127:0] data;} lit_t;
  exp_t q0[$], q1[$], q2[$];
  lit_t lits[$];
  int cyc = 0, vectors = 0, errors = 0, last_due = 0, nlit = 0;
  int dw [3] = '{32, 32, 16};
  bit se [3] = '{1'b0, 1'b1, 1'b0};
  logic [4:0] map [6] = '{RA, RB, RC, RD, RE, RF};
  logic [5:0] fl [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02};
  logic [31:0] mreg [3][6];
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int find(input logic [4:0] a);
    for (int i = 0; i < 6; i++) if (map[i] == a) return i;
    return -1;
  endfunction
  function automatic logic [31:0] msk(input logic [31:0] v, input int w);
    return w >= 32 ? v : v & ((32'd1 << w) - 32'd1);
  endfunction
  function automatic longint sx(input logic [31:0] v, input int w);
    return v[w-1] ? longint'(v) - (longint'(1) << w) : longint'(v);
  endfunction
  function automatic logic [31:0] rt_(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] it_(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  // Architectural model: execute each instruction in program order, then read the slots.
  task automatic model(input int d, input logic [31:0] ins, input logic [19:0] oreg, input int due);
    exp_t e;
    logic [5:0] op, fn;
    logic [31:0] a, b, r, ext;
    int rs, rt, rd, sh, w, idx;
    bit ok;
    op = ins[31:26]; fn = ins[5:0]; sh = int'(ins[10:6]); w = dw[d];
    rs = find(ins[25:21]); rt = find(ins[20:16]); rd = find(ins[15:11]);
    ok = (op == 6'h00 || op == 6'h08) && rs >= 0 && rt >= 0 &&
         (op == 6'h08 || (rd >= 0 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02}));
    e.due = due; e.fail = !ok; e.data = '0;
    if (ok) begin
      a = mreg[d][rs]; b = mreg[d][rt];
      ext = se[d] ? {{16{ins[15]}}, ins[15:0]} : {16'd0, ins[15:0]};
      r = '0;
      if (op == 6'h08) r = a + ext;
      else case (fn)
        6'h20: r = a + b;
        6'h22: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h27: r = ~(a | b);
        6'h2a: r = (sx(a, w) < sx(b, w)) ? 32'd1 : 32'd0;
        6'h00: r = sh >= w ? 32'd0 : a << sh;
        default: r = sh >= w ? 32'd0 : a >> sh;
      endcase
      mreg[d][op == 6'h08 ? rt : rd] = msk(r, w);
      for (int k = 0; k < 4; k++) begin
        idx = find(oreg[5*k+:5]);
        if (idx >= 0) e.data |= 128'(mreg[d][idx]) << (k * w);
      end
    end
    if (d == 0) q0.push_back(e); else if (d == 1) q1.push_back(e); else q2.push_back(e);
  endtask
  task automatic issue(input logic [31:0] ins, input logic [19:0] oreg);
    @(posedge clk); #1;
    in_valid = 1'b1; instruction = ins; output_reg = oreg;
    last_due = cyc + 4;
    for (int d = 0; d < 3; d++) model(d, ins, oreg, last_due);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0; instruction = $urandom; output_reg = 20'($urandom);
    end
  endtask
  task automatic lit(input int d, input bit fail, input logic [127:0] data);
    lits.push_back('{d, last_due, nlit, fail, data});
    nlit++;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); lits.delete();
    for (int d = 0; d < 3; d++) for (int i = 0; i < 6; i++) mreg[d][i] = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
  endtask
  function automatic logic [4:0] rreg();
    return $urandom_range(9) == 0 ? 5'($urandom) : map[$urandom_range(5)];
  endfunction
  function automatic logic [31:0] rins();
    int r;
    r = $urandom_range(19);
    if (r == 0) return $urandom;
    if (r < 7) return it_(6'h08, rreg(), rreg(), 16'($urandom));
    return rt_(rreg(), rreg(), rreg(), 5'($urandom), r == 19 ? 6'($urandom) : fl[$urandom_range(7)]);
  endfunction
  // Single compare process: out_valid every cycle, payload when due, plus pinned literals.
  always @(negedge clk) begin
    bit ev;
    exp_t e;
    lit_t l;
    for (int d = 0; d < 3; d++) begin
      e = '{0, 1'b0, '0};
      ev = 1'b0;
      if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin ev = 1'b1; e = q0.pop_front(); end
      if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin ev = 1'b1; e = q1.pop_front(); end
      if (d == 2 && q2.size() > 0 && q2[0].due == cyc) begin ev = 1'b1; e = q2.pop_front(); end
      vectors++;
      if (ov[d] !== ev) begin
        errors++;
        $display("FAIL out_valid dut%0d cyc %0d: got %b expected %b", d, cyc, ov[d], ev);
      end
      if (ev) begin
        vectors++;
        if (of[d] !== e.fail || od[d] !== e.data) begin
          errors++;
          $display("FAIL result dut%0d cyc %0d: got fail=%b data=%h expected fail=%b data=%h", d, cyc, of[d], od[d], e.fail, e.data);
        end
      end
    end
    while (lits.size() > 0 && lits[0].due == cyc) begin
      l = lits.pop_front();
      vectors++;
      if (ov[l.d] !== 1'b1 || of[l.d] !== l.fail || od[l.d] !== l.data) begin
        errors++;
        $display("FAIL lit%0d dut%0d: got v=%b fail=%b data=%h expected v=1 fail=%b data=%h", l.id, l.d, ov[l.d], of[l.d], od[l.d], l.fail, l.data);
      end
    end
  end
  initial begin
    rst_n = 1'b1;
    do_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (ov[d] !== 1'b0 || of[d] !== 1'b0 || od[d] !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got v=%b fail=%b data=%h expected all 0", d, ov[d], of[d], od[d]);
      end
    end
    issue(it_(6'h08, RA, RA, 16'd5), ORD);
    for (int d = 0; d < 3; d++) lit(d, 1'b0, 128'd5);
    issue(rt_(RA, RA, RB, 5'd0, 6'h20), ORD);
    lit(0, 1'b0, {32'd0, 32'd0, 32'd10, 32'd5});
    lit(2, 1'b0, {64'd0, 16'd0, 16'd0, 16'd10, 16'd5});
    issue(it_(6'b100011, RA, RA, 16'd1), ORD);
    lit(0, 1'b1, '0);
    issue(rt_(RA, RA, RA, 5'd0, 6'b011000), ORD);
    lit(0, 1'b1, '0);
    issue(it_(6'h08, 5'b00001, RA, 16'd7), ORD);
    lit(0, 1'b1, '0);
    issue(it_(6'h08, RC, RC, 16'd0), ORD);
    lit(0, 1'b0, {32'd0, 32'd0, 32'd10, 32'd5});
    issue(it_(6'h08, RF, RC, 16'hFFFF), ORD);
    lit(0, 1'b0, {32'd0, 32'h0000FFFF, 32'd10, 32'd5});
    lit(1, 1'b0, {32'd0, 32'hFFFFFFFF, 32'd10, 32'd5});
    issue(rt_(RC, RF, RD, 5'd0, 6'h2a), ORD);
    lit(0, 1'b0, {32'd0, 32'h0000FFFF, 32'd10, 32'd5});
    lit(1, 1'b0, {32'd1, 32'hFFFFFFFF, 32'd10, 32'd5});
    issue(it_(6'h08, RF, RE, 16'd1), ORD);
    issue(rt_(RE, RF, RB, 5'd31, 6'h00), ORD);
    lit(0, 1'b0, {32'd0, 32'h0000FFFF, 32'h80000000, 32'd5});
    lit(2, 1'b0, {64'd0, 16'd1, 16'hFFFF, 16'd0, 16'd5});
    issue(rt_(RB, RF, RC, 5'd31, 6'h02), ORD);
    lit(0, 1'b0, {32'd0, 32'd1, 32'h80000000, 32'd5});
    issue(rt_(RE, RF, RB, 5'd20, 6'h00), ORD);
    lit(0, 1'b0, {32'd0, 32'd1, 32'h00100000, 32'd5});
    lit(2, 1'b0, {64'd0, 16'd1, 16'd0, 16'd0, 16'd5});
    issue(it_(6'h08, RA, RA, 16'd1), ORD);
    idle(1);
    issue(it_(6'h08, RA, RA, 16'd1), ORD);
    idle(2);
    issue(it_(6'h08, RA, RA, 16'd1), ORD);
    lit(0, 1'b0, {32'd0, 32'd1, 32'h00100000, 32'd8});
    idle(5);
    issue(it_(6'h08, RB, RB, 16'd3), ORD);
    issue(it_(6'h08, RC, RC, 16'd4), ORD);
    issue(rt_(RB, RC, RD, 5'd0, 6'h20), ORD);
    do_reset();
    idle(5);
    issue(it_(6'h08, RF, RF, 16'd0), ORD);
    for (int d = 0; d < 3; d++) lit(d, 1'b0, '0);
    idle(5);
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      if ($urandom_range(3) == 0) idle(1);
      else issue(rins(), {rreg(), rreg(), rreg(), rreg()});
    end
    idle(8);
    vectors++;
    if (q0.size() + q1.size() + q2.size() + lits.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", q0.size() + q1.size() + q2.size() + lits.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mips_pipe_param.md
Name: mips_pipe_param

Overview:
Parametrised successor to the team's fixed 4-stage, 6-register MIPS subset pipeline. It executes one R-type or ADDI instruction per cycle against a small mapped register file. It reports NUM_OUT register values (or instruction_fail) exactly 4 cycles after input. New relative to the previous generation:
- configurable data width, register count/address map and output count
- EX→operand forwarding, so back-to-back dependent instructions see fresh values
- SUB and SLT
- selectable immediate extension

Parameters:
DATA_W, 32, datapath/register width
NUM_REGS, 6, number of architectural registers
REG_MAP, {5'b10000,5'b11111,5'b10111,5'b01000,5'b10010,5'b10001}, NUM_REGS×5-bit addresses; entry i = address of reg i (entry 0 in LSBs)
NUM_OUT, 4, number of readout ports
SIGN_EXT, 0, 1 = ADDI immediate sign-extended, 0 = zero-extended

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-high (asserted when 1)
in_valid  in  1  instruction/output_reg valid this cycle
instruction  in  32  MIPS instruction word
output_reg  in  NUM_OUT*5  readout addresses; slot k = bits [5k+4:5k]
out_valid  out  1  result valid
instruction_fail  out  1  instruction rejected
out_data  out  NUM_OUT*DATA_W  slot k = register value for output_reg slot k

Behaviour:
- Reset (async, rst_n=1): clear all stage valids, register file, out_valid, instruction_fail and out_data to 0. Reset mid-stream drops in-flight instructions; no writeback after release until new input.
- Stages:
  - S1: capture instruction and output_reg when in_valid.
  - S2: decode, legality check, operand read; capture at edge.
  - S3: ALU, register-file write at end of cycle.
  - S4: read register file for output slots; outputs registered.
- Latency: in_valid at cycle T → out_valid=1 at cycle T+4, for exactly one cycle per valid input. Bubbles propagate with no writeback and out_valid=0.
- Legality (any failure → fail):
  - opcode ∈ {000000 R, 001000 ADDI}
  - RS and RT ∈ REG_MAP
  - for R-type: RD ∈ REG_MAP and funct ∈ {100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt, 000000 sll, 000010 srl}
- Failed instruction: no writeback; at its output cycle instruction_fail=1, out_valid=1, out_data=0.
- ALU results:
  - add/sub: mod 2^DATA_W
  - slt: signed compare, result 1 or 0
  - sll/srl: shift RS by SHAMT (logical); SHAMT ≥ DATA_W → 0
  - ADDI: RT ← RS + ext(imm16), ext per SIGN_EXT, truncated/extended to DATA_W
- Forwarding: if the instruction in S3 writes register r and the S2 instruction reads r (RS and/or RT), the S2 instruction takes the S3 ALU result, not the stale file value.
- Readout: out_data reflects register state after this instruction's own writeback and all earlier ones; no later instruction's writeback is visible.
- Slot address not in REG_MAP: that slot outputs 0, with no fail.
- Duplicate REG_MAP entries are illegal configuration; behaviour is undefined.

Decomposition:
- Package mips_pipe_pkg: opcode/funct localparams, default REG_MAP, and a function for address→index lookup plus hit flag.
- Sub-module mips_pipe_alu: combinational; inputs funct, shamt, operands, imm, is_rtype; output result.

Test Plan:
1. Reset, then ADDI rt=10001 rs=10001 imm=5, output_reg slot0=10001 → at T+4 out_valid=1, slot0=5, instruction_fail=0.
2. Forwarding: ADDI 10001←10001+5 immediately followed by add rd=10010 rs=rt=10001, slot0=10010 → second result slot0=10 (not 0).
3. Illegal: opcode 100011, then funct 011000, then RS=00001 → each gives instruction_fail=1, out_data=0, register file unchanged (verified by a later readout).
4. With SIGN_EXT=1: ADDI imm=16'hFFFF onto 0 → 32'hFFFFFFFF; slt of FFFFFFFF vs 0 → 1; with SIGN_EXT=0 the same ADDI → 32'h0000FFFF.
5. Shift: reg=1, sll shamt=31 → 32'h80000000; srl shamt=31 → 1; with DATA_W=16 and shamt=20 → 0.
6. Bubbles and reset: valid, gap, valid sequence keeps 4-cycle spacing per input. Assert rst_n while 3 instructions are in flight → no out_valid afterwards and all registers read 0.
